// File: rtl/wb_sequencer.sv
// wb_sequencer: multi-cycle writeback controller for the 16-bit RISC datapath.
// It accepts one writeback request at a time and drives the 3-way writeback
// mux select. The select values are 00 for the sign-extended immediate, 01 for
// data-memory read data and 10 for store/forward data. A load issues a
// one-cycle memory read and waits for read-valid under a timeout. The
// controller then pulses the register-file write strobe.
//
// Ports:
//   clk, rst         clock (rising edge), synchronous active-high reset
//   req_valid/ready  request handshake; ready is high only in IDLE
//   req_kind         00 immediate, 01 memory load, 10/11 direct data
//   req_rd           destination register
//   req_addr         data-memory address (loads only)
//   mem_rd_en        one-cycle data-memory read strobe
//   mem_addr         data-memory read address, held after the read
//   mem_rd_valid     memory read data valid
//   m5_sel           writeback mux select, held from acceptance to next request
//   rf_we, rf_waddr  one-cycle register-file write strobe and address
//   busy             high whenever the controller is not IDLE
//   timeout_err      one-cycle pulse when a load is aborted
module wb_sequencer #(
  parameter int N       = 16,
  parameter int RF_AW   = 3,
  parameter int TIMEOUT = 15,
  parameter int TW      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_kind,
  input  logic [RF_AW-1:0] req_rd,
  input  logic [N-1:0]     req_addr,
  output logic             mem_rd_en,
  output logic [N-1:0]     mem_addr,
  input  logic             mem_rd_valid,
  output logic [1:0]       m5_sel,
  output logic             rf_we,
  output logic [RF_AW-1:0] rf_waddr,
  output logic             busy,
  output logic             timeout_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_WAIT = 2'd2,
    WRITE    = 2'd3
  } state_t;

  // The wait counter holds the index of the current MEM_WAIT cycle, so the
  // abort fires at the end of the TIMEOUT-th wait cycle.
  localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

  state_t        state_r;
  logic [TW-1:0] cnt_r;

  // Handshake and status decode straight from the state register.
  assign req_ready = (state_r == IDLE);
  assign busy      = (state_r != IDLE);

  // Controller FSM. The latched kind, rd and addr live directly in the
  // m5_sel, rf_waddr and mem_addr output registers. The strobes are computed
  // from the next state, so they appear in the cycle of the state they
  // belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      m5_sel      <= 2'b00;
      rf_we       <= 1'b0;
      rf_waddr    <= '0;
      mem_rd_en   <= 1'b0;
      mem_addr    <= '0;
      timeout_err <= 1'b0;
    end else begin
      rf_we       <= 1'b0;
      mem_rd_en   <= 1'b0;
      timeout_err <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            rf_waddr <= req_rd;
            if (req_kind == 2'b01) begin
              // mem_addr only moves on a load, so it keeps the last read address.
              m5_sel    <= 2'b01;
              mem_addr  <= req_addr;
              mem_rd_en <= 1'b1;
              state_r   <= MEM_REQ;
            end else begin
              // Kinds 10 and 11 both select store/forward data.
              m5_sel  <= (req_kind == 2'b00) ? 2'b00 : 2'b10;
              rf_we   <= 1'b1;
              state_r <= WRITE;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        MEM_REQ: begin
          // Read-valid is not looked at here; the memory answers no earlier
          // than the first wait cycle.
          cnt_r   <= '0;
          state_r <= MEM_WAIT;
        end
        MEM_WAIT: begin
          if (mem_rd_valid) begin
            // Data arriving on the last wait cycle still wins over the abort.
            rf_we   <= 1'b1;
            state_r <= WRITE;
          end else if (cnt_r == CNT_LAST) begin
            timeout_err <= 1'b1;
            state_r     <= IDLE;
          end else begin
            cnt_r   <= cnt_r + TW'(1);
            state_r <= MEM_WAIT;
          end
        end
        WRITE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_sequencer.sv
// Scoreboard bench for wb_sequencer. The stimulus pushes the expected events
// (read strobe, write strobe, timeout pulse) together with the cycle of each.
// A monitor pops them whenever the DUT shows a strobe and compares them.
module tb_wb_sequencer;

  localparam int TIMEOUT = 15;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_kind;
  logic [2:0]  req_rd;
  logic [15:0] req_addr;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic        mem_rd_valid;
  logic [1:0]  m5_sel;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic        busy;
  logic        timeout_err;

  wb_sequencer #(.N(16), .RF_AW(3), .TIMEOUT(TIMEOUT), .TW(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
    .req_rd(req_rd), .req_addr(req_addr),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_valid(mem_rd_valid),
    .m5_sel(m5_sel), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .busy(busy), .timeout_err(timeout_err)
  );

  // Event kinds: 0 register write, 1 memory read, 2 timeout pulse.
  typedef struct {
    int          kind;
    int          cyc;
    logic [15:0] val;
    logic [1:0]  sel;
  } ev_t;

  ev_t q[$];
  int  dly_q[$];
  int  cyc = 0;
  int  n_cmp = 0;
  int  n_bad = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  initial begin
    ev_t e;
    int  k;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && (rf_we === 1'b1 || mem_rd_en === 1'b1 || timeout_err === 1'b1)) begin
        k = (rf_we === 1'b1) ? 0 : ((mem_rd_en === 1'b1) ? 1 : 2);
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", k, cyc);
        end else begin
          e = q.pop_front();
          chk("ev_kind", 32'(k), 32'(e.kind));
          chk("ev_cycle", 32'(cyc), 32'(e.cyc));
          if (e.kind == 0) begin
            chk("wr_m5_sel", {30'd0, m5_sel}, {30'd0, e.sel});
            chk("rf_waddr", {29'd0, rf_waddr}, {16'd0, e.val});
          end else if (e.kind == 1) begin
            chk("rd_m5_sel", {30'd0, m5_sel}, 32'd1);
            chk("mem_addr", {16'd0, mem_addr}, {16'd0, e.val});
          end
        end
      end
    end
  end

  // Memory responder: raises read-valid for one cycle, d cycles after the
  // read strobe (d < 0 means never, d == 0 lands in MEM_REQ).
  initial begin
    int d;
    int due;
    bit pend;
    pend = 1'b0;
    due = 0;
    mem_rd_valid = 1'b0;
    forever begin
      @(negedge clk);
      mem_rd_valid = 1'b0;
      if (rst === 1'b1) pend = 1'b0;
      if (rst === 1'b0 && mem_rd_en === 1'b1 && dly_q.size() > 0) begin
        d = dly_q.pop_front();
        if (d >= 0) begin
          pend = 1'b1;
          due = cyc + d;
        end
      end
      if (pend && cyc == due) begin
        mem_rd_valid = 1'b1;
        pend = 1'b0;
      end
    end
  end

  // Present one request and push its expected events. The task returns at the
  // negedge after acceptance, with req_valid still high.
  task automatic issue(input logic [1:0] k, input logic [2:0] rd, input logic [15:0] a,
                       input int dly, output int acc);
    int guard;
    int e;
    ev_t ev;
    req_valid = 1'b1;
    req_kind = k;
    req_rd = rd;
    req_addr = a;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (req_ready !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_wait: got req_ready %b, expected 1 within 100 cycles", req_ready);
    end
    acc = cyc + 1;
    if (k == 2'b01) begin
      e = acc;
      ev.kind = 1; ev.cyc = e; ev.val = a; ev.sel = 2'b01;
      q.push_back(ev);
      dly_q.push_back(dly);
      if (dly >= 1 && dly <= TIMEOUT) begin
        ev.kind = 0; ev.cyc = e + dly + 1; ev.val = {13'd0, rd}; ev.sel = 2'b01;
      end else begin
        ev.kind = 2; ev.cyc = e + TIMEOUT + 1; ev.val = 16'd0; ev.sel = 2'b01;
      end
      q.push_back(ev);
    end else begin
      ev.kind = 0; ev.cyc = acc; ev.val = {13'd0, rd};
      ev.sel = (k == 2'b00) ? 2'b00 : 2'b10;
      q.push_back(ev);
    end
    @(negedge clk);
    chk("ready_low_busy", {31'd0, req_ready}, 32'd0);
  endtask

  task automatic drain();
    int guard;
    req_valid = 1'b0;
    guard = 0;
    while (q.size() > 0 && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d events pending, expected 0", q.size());
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int a0;
    int a1;
    int a2;
    int a3;
    rst = 1'b1;
    req_valid = 1'b0;
    req_kind = 2'b00;
    req_rd = 3'd0;
    req_addr = 16'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state.
    chk("rst_m5_sel", {30'd0, m5_sel}, 32'd0);
    chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst_mem_rd_en", {31'd0, mem_rd_en}, 32'd0);
    chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    chk("rst_rf_waddr", {29'd0, rf_waddr}, 32'd0);
    chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);

    // Immediate write.
    issue(2'b00, 3'd5, 16'h0000, 0, a0);
    drain();
    chk("imm_ready_after", {31'd0, req_ready}, 32'd1);

    // Load answered 3 cycles after the read strobe.
    issue(2'b01, 3'd3, 16'h00A4, 3, a0);
    drain();

    // Load never answered: abort.
    issue(2'b01, 3'd6, 16'h1234, -1, a0);
    drain();
    chk("timeout_idle", {31'd0, busy}, 32'd0);
    chk("timeout_sel_hold", {30'd0, m5_sel}, 32'd1);

    // Load answered on the last wait cycle: the write wins.
    issue(2'b01, 3'd2, 16'hBEEF, TIMEOUT, a0);
    drain();

    // Valid during MEM_REQ only is ignored, so the load aborts.
    issue(2'b01, 3'd1, 16'h0F0F, 0, a0);
    drain();

    // Kind 11 behaves as direct data.
    issue(2'b11, 3'd7, 16'h0000, 0, a0);
    drain();
    chk("k11_sel_hold", {30'd0, m5_sel}, 32'd2);

    // Back-to-back stream with req_valid held throughout.
    issue(2'b00, 3'd1, 16'h0000, 0, a0);
    issue(2'b10, 3'd4, 16'h0000, 0, a1);
    issue(2'b01, 3'd6, 16'h0042, 1, a2);
    issue(2'b00, 3'd0, 16'h0000, 0, a3);
    drain();
    chk("b2b_spacing", 32'(a1 - a0), 32'd2);
    chk("b2b_load_spacing", 32'(a3 - a2), 32'd4);
    chk("b2b_sel_hold", {30'd0, m5_sel}, 32'd0);
    chk("b2b_mem_addr_hold", {16'd0, mem_addr}, 32'h0042);

    // Reset while in MEM_WAIT: back to IDLE, no write, no abort pulse.
    issue(2'b01, 3'd5, 16'h00C0, -1, a0);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("mid_rst_sel", {30'd0, m5_sel}, 32'd0);
    repeat (25) @(negedge clk);
    chk("final_queue_empty", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_sequencer.md
Name: wb_sequencer

Overview:
Multi-cycle writeback controller for the 16-bit RISC datapath. It accepts one writeback request at a time and drives the writeback source select for the 3-way writeback mux: 00 sign-extended immediate, 01 data-memory read data, 1x store/forward data. For memory loads it issues the data-memory read, waits for read-valid under a timeout, and then produces the register-file write strobe with the destination address.

Parameters:
N, 16, datapath/address width
RF_AW, 3, register-file address width
TIMEOUT, 15, maximum MEM_WAIT cycles before abort (>=1)
TW, 4, timeout counter width; must hold TIMEOUT

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  writeback request present
req_ready  out  1  controller can accept a request (high only in IDLE)
req_kind  in  2  00 immediate, 01 memory load, 10/11 direct data
req_rd  in  RF_AW  destination register
req_addr  in  N  data-memory address (used only for kind 01)
mem_rd_en  out  1  data-memory read strobe, one cycle
mem_addr  out  N  data-memory read address
mem_rd_valid  in  1  memory read data valid
m5_sel  out  2  writeback mux select
rf_we  out  1  register-file write enable, one cycle
rf_waddr  out  RF_AW  register-file write address
busy  out  1  high whenever state != IDLE
timeout_err  out  1  one-cycle pulse on load abort

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: state IDLE; all latched fields 0. Outputs: m5_sel=00, rf_we=0, mem_rd_en=0, timeout_err=0, rf_waddr=0, mem_addr=0.
- Reset mid-operation returns to IDLE. No rf_we and no further mem_rd_en are issued.
- States: IDLE, MEM_REQ, MEM_WAIT, WRITE. Encoding is free.
- req_ready is combinational and equals (state==IDLE).
- A transfer occurs when req_valid && req_ready. On transfer, latch kind, rd and addr.
  - kind 01: next state MEM_REQ.
  - any other kind: next state WRITE.
  - kind 11 is latched as 10.
- MEM_REQ (1 cycle): mem_rd_en=1, mem_addr=latched addr. Clear the timeout counter. Go to MEM_WAIT. mem_rd_valid is ignored in this state.
- MEM_WAIT:
  - mem_rd_valid=1: go to WRITE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 with valid still low, pulse timeout_err for one cycle (registered, visible the cycle after) and return to IDLE with no write.
  - Valid arriving in the same cycle as the timeout wins: go to WRITE, no error.
- WRITE (1 cycle): rf_we=1, rf_waddr=latched rd. Next state IDLE.
- m5_sel is driven continuously from the latched kind. It is stable from the cycle after acceptance through WRITE, and holds its value in IDLE until the next transfer. The mux is combinational, so m5_sel must never change during WRITE.
- mem_addr holds its value after MEM_REQ.
- Latency, with acceptance at edge T:
  - Immediate/direct: rf_we high during cycle T+1.
  - Load with valid at first MEM_WAIT cycle: mem_rd_en high during T+1, valid sampled during T+2, rf_we high during T+3.
- Back-to-back: a new request can be accepted in the cycle the controller is back in IDLE, i.e. the cycle after WRITE. Throughput is therefore one non-load writeback every 2 cycles.
- mem_rd_valid arriving while in IDLE, WRITE or MEM_REQ is ignored.
- req_valid while busy has no effect (req_ready=0). The requester holds the request.

Test Plan:
- Reset, then check all outputs 0 and req_ready=1. Assert rst during MEM_WAIT -> next cycle IDLE, rf_we never pulses.
- Immediate: req_kind=00, req_rd=5 -> m5_sel=00, rf_we=1, rf_waddr=5 exactly one cycle after acceptance, then req_ready=1.
- Load: req_kind=01, req_addr=16'h00A4, req_rd=3, mem_rd_valid 3 cycles after mem_rd_en -> mem_rd_en one cycle with mem_addr=00A4; m5_sel=01; rf_we, rf_waddr=3 the cycle after valid.
- Timeout: TIMEOUT=15, load with mem_rd_valid never asserted -> timeout_err single pulse, no rf_we, return to IDLE. Repeat with valid on the final wait cycle -> write occurs, no error.
- Kind 11, req_rd=7 -> m5_sel=10, rf_we with rf_waddr=7. Back-to-back imm/direct/load stream with req_valid held -> req_ready low while busy, each write uses the correct select and address, no dropped or duplicated rf_we.
